// File: rtl/decode_issue_queue.sv
// Decode-to-execute issue FIFO (first-word-fall-through) with an FP busy
// scoreboard that holds back the head entry while it has a RAW/WAW hazard on a long FP op.
module decode_issue_queue #(
  parameter int PAYLOAD_W = 160,
  parameter int DEPTH     = 2,
  parameter int REG_AW    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [REG_AW-1:0]            in_rd,
  input  logic [REG_AW-1:0]            in_rs1,
  input  logic [REG_AW-1:0]            in_rs2,
  input  logic                         in_rd_fp,
  input  logic                         in_src_fp,
  input  logic                         in_long,
  input  logic                         wb_clr_valid,
  input  logic [REG_AW-1:0]            wb_clr_rd,
  input  logic                         flush,
  input  logic                         o_p_waitrequest,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [REG_AW-1:0]            out_rd,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [2**REG_AW-1:0]         busy_fp
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int NREG  = 2**REG_AW;

  logic [PAYLOAD_W-1:0] payload_mem [DEPTH];
  logic [REG_AW-1:0]    rd_mem      [DEPTH];
  logic [REG_AW-1:0]    rs1_mem     [DEPTH];
  logic [REG_AW-1:0]    rs2_mem     [DEPTH];
  logic [DEPTH-1:0]     rd_fp_mem;
  logic [DEPTH-1:0]     src_fp_mem;
  logic [DEPTH-1:0]     long_mem;

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [NREG-1:0]  busy_reg, busy_next;

  logic full, empty, hazard, enq, deq, set_en;
  logic [REG_AW-1:0] head_rd, head_rs1, head_rs2;
  logic head_rd_fp, head_src_fp, head_long;

  assign head_rd     = rd_mem[rd_ptr_reg];
  assign head_rs1    = rs1_mem[rd_ptr_reg];
  assign head_rs2    = rs2_mem[rd_ptr_reg];
  assign head_rd_fp  = rd_fp_mem[rd_ptr_reg];
  assign head_src_fp = src_fp_mem[rd_ptr_reg];
  assign head_long   = long_mem[rd_ptr_reg];

  assign full   = (count_reg == CNT_W'(DEPTH));
  assign empty  = (count_reg == '0);
  assign hazard = (head_src_fp && (busy_reg[head_rs1] || busy_reg[head_rs2]))
                || (head_rd_fp && busy_reg[head_rd]);

  assign in_ready  = !full && !flush;
  assign out_valid = !empty && !hazard && !flush;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready && !o_p_waitrequest;
  assign set_en    = deq && head_long && head_rd_fp;

  assign out_payload = payload_mem[rd_ptr_reg];
  assign out_rd      = head_rd;
  assign count       = count_reg;
  assign busy_fp     = busy_reg;

  // A register set by an issuing long op and released in the same cycle stays busy.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    assign busy_next[gi] = (set_en && head_rd == REG_AW'(gi))
                        || (busy_reg[gi] && !(wb_clr_valid && wb_clr_rd == REG_AW'(gi)));
  end

  always_comb begin
    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= '0;
      rd_fp_mem  <= '0;
      src_fp_mem <= '0;
      long_mem   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        payload_mem[i] <= '0;
        rd_mem[i]      <= '0;
        rs1_mem[i]     <= '0;
        rs2_mem[i]     <= '0;
      end
    end else begin
      busy_reg <= busy_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        count_reg <= count_next;
        if (enq) begin
          payload_mem[wr_ptr_reg] <= in_payload;
          rd_mem[wr_ptr_reg]      <= in_rd;
          rs1_mem[wr_ptr_reg]     <= in_rs1;
          rs2_mem[wr_ptr_reg]     <= in_rs2;
          rd_fp_mem[wr_ptr_reg]   <= in_rd_fp;
          src_fp_mem[wr_ptr_reg]  <= in_src_fp;
          long_mem[wr_ptr_reg]    <= in_long;
          wr_ptr_reg              <= wr_ptr_reg + PTR_W'(1);
        end
        if (deq) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end
endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Parametrised decode-to-execute issue buffer replacing the single-entry decode pipeline register. Holds up to DEPTH decoded micro-ops (opaque payload plus register indices) in a first-word-fall-through FIFO with valid/ready handshakes on both sides. Tracks in-flight multi-cycle FP operations in a per-register busy scoreboard and withholds the head entry on RAW/WAW hazards against them. Honours the data-memory `o_p_waitrequest` stall and a front-end flush.

## Interface
- PAYLOAD_W, 160, width of opaque decoded control/operand bundle
- DEPTH, 2, entries; power of two, >= 2
- REG_AW, 5, register index width; scoreboard has 2**REG_AW bits
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  decode offers an entry
- in_ready  out  1  queue accepts this cycle
- in_payload  in  PAYLOAD_W  decoded bundle
- in_rd, in_rs1, in_rs2  in  REG_AW each  destination / source indices
- in_rd_fp  in  1  destination is FP register file
- in_src_fp  in  1  sources read FP register file
- in_long  in  1  multi-cycle FP op (fdiv/fsqrt/fmul); marks scoreboard on issue
- wb_clr_valid  in  1  long FP op completed writeback
- wb_clr_rd  in  REG_AW  FP register being released
- flush  in  1  discard all queued entries
- o_p_waitrequest  in  1  memory stall; freezes dequeue
- out_valid  out  1  head entry issuable
- out_ready  in  1  execute accepts head
- out_payload  out  PAYLOAD_W  head bundle
- out_rd  out  REG_AW  head destination
- count  out  $clog2(DEPTH+1)  occupancy
- busy_fp  out  2**REG_AW  scoreboard vector

## Operation
- Enqueue: in_valid && in_ready. in_ready = !full && !flush. Each entry stores payload, rd, rs1, rs2, rd_fp, src_fp, long.
- Head fields drive out_* combinationally from storage at read pointer.
- hazard = head.src_fp && (busy_fp[rs1] || busy_fp[rs2]) || head.rd_fp && busy_fp[rd].
- out_valid = !empty && !hazard && !flush.
- Dequeue: out_valid && out_ready && !o_p_waitrequest.
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy (+1 enq, -1 deq, unchanged on both).
- Scoreboard set: on dequeue with head.long && head.rd_fp, busy_fp[head.rd] <= 1.
- Scoreboard clear: wb_clr_valid clears busy_fp[wb_clr_rd]. Same register set and cleared in one cycle: set wins.
- Flush: next cycle count = 0, pointers equal; no enqueue or dequeue in the flush cycle. Scoreboard untouched (in-flight ops still write back); clears still applied.
- o_p_waitrequest high: no dequeue, no scoreboard set; enqueue continues while not full.
- Full and out dequeue in same cycle: in_ready stays 0 (no pass-through); space visible next cycle.

## Timing
- Reset (rst=0 at a rising edge): count=0, pointers=0, busy_fp=0, all storage cleared, so out_valid=0, out_payload=0, out_rd=0; in_ready=1 from the first cycle after reset release.
- Enqueue-to-issue latency: 1 cycle (entry accepted at edge N is out_valid after edge N, absent hazard/stall).
- Throughput: one enqueue and one dequeue per cycle.
- Hazard release: wb_clr_valid at edge N; out_valid rises after edge N.
- Reset mid-operation discards queue and scoreboard at that edge.
- in_ready, out_valid are combinational from registered state plus flush.

## Test plan
- Reset then enqueue payload 0xA5 (rd=3) at cycle 1, out_ready=1 -> out_valid=1 cycle 2 with out_payload=0xA5, count returns 0 cycle 3.
- DEPTH=2, out_ready=0, offer 3 entries -> first two accepted, in_ready=0 with count=2; third held; release out_ready -> order A,B,C preserved, pointers wrap correctly.
- Issue long FP op rd=f5; next entry src_fp rs1=5 -> out_valid=0 until wb_clr_valid rd=5, then out_valid=1 the following cycle; busy_fp[5] 1 -> 0.
- Same-cycle issue of long rd=f7 and wb_clr_rd=7 -> busy_fp[7]=1 afterward.
- Queue count=2, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, offered entry dropped, busy_fp unchanged.
- o_p_waitrequest=1 for 3 cycles with head valid and out_ready=1 -> no dequeue, count constant, enqueues fill to DEPTH; deassert -> dequeue resumes next edge.
